// File: rtl/xor86_pkg.sv
// Shared definitions for the 74xx86 quad XOR pin model.
package xor86_pkg;

    localparam int unsigned NUM_GATES     = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

endpackage : xor86_pkg

// File: rtl/xor86_gate.sv
// Single 2-input XOR gate of the 74xx86, with an optional saturating toggle counter.
// Optional feature macro: XOR86_ACTIVITY_EN (adds clk/rst/tog ports and counter).
// Ports:
//   a, b   gate inputs
//   y      combinational output a ^ b (X propagates)
//   clk    system clock (activity build only)
//   rst    synchronous active-high reset (activity build only)
//   tog    saturating count of y transitions (activity build only)
module xor86_gate
`ifdef XOR86_ACTIVITY_EN
#(
    parameter int unsigned CNT_W = 8
)
`endif
(
`ifdef XOR86_ACTIVITY_EN
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] tog,
`endif
    input  logic             a,
    input  logic             b,
    output logic             y
);

    // Bitwise XOR keeps X/Z on an input visible on the output.
    assign y = a ^ b;

`ifdef XOR86_ACTIVITY_EN
    logic             prev_q;
    logic             prev_d;
    logic [CNT_W-1:0] tog_q;
    logic [CNT_W-1:0] tog_d;
    logic             toggled_c;

    // Case equality makes an unknown y count as no toggle.
    assign toggled_c = ((y ^ prev_q) === 1'b1);

    // Next state: reset clears, otherwise count toggles up to all-ones.
    always_comb begin
        prev_d = y;
        tog_d  = tog_q;
        if (rst) begin
            prev_d = 1'b0;
            tog_d  = '0;
        end else if (toggled_c && (tog_q != {CNT_W{1'b1}})) begin
            tog_d = tog_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        tog_q  <= tog_d;
    end

    assign tog = tog_q;
`endif

endmodule : xor86_gate

// File: rtl/xor_86p.sv
// Pin-level 74xx86 quad 2-input XOR model with a registered probe copy of the outputs.
// Optional feature macro: XOR86_ACTIVITY_EN adds tog1..tog4 per-gate toggle counters.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset (clears y_q and counters only)
//   a1..a4      gate A inputs (pins 1,4,9,12)
//   b1..b4      gate B inputs (pins 2,5,10,13)
//   y1..y4      combinational gate outputs (pins 3,6,8,11)
//   y_q         registered {y4,y3,y2,y1}
//   tog1..tog4  per-gate saturating toggle counts (activity build only)
module xor_86p
    import xor86_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             a1,
    input  logic             a2,
    input  logic             a3,
    input  logic             a4,
    input  logic             b1,
    input  logic             b2,
    input  logic             b3,
    input  logic             b4,
    output logic             y1,
    output logic             y2,
    output logic             y3,
    output logic             y4,
`ifdef XOR86_ACTIVITY_EN
    output logic [CNT_W-1:0] tog1,
    output logic [CNT_W-1:0] tog2,
    output logic [CNT_W-1:0] tog3,
    output logic [CNT_W-1:0] tog4,
`endif
    output gate_vec_t        y_q
);

    // Counter width must be usable even when counters are compiled out.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("xor_86p: CNT_W must be at least 1");
    end

    gate_vec_t a_w;
    gate_vec_t b_w;
    gate_vec_t y_w;
    gate_vec_t y_q_d;

    // Pin names onto gate vectors, bit 0 = gate 1.
    assign a_w = {a4, a3, a2, a1};
    assign b_w = {b4, b3, b2, b1};
    assign {y4, y3, y2, y1} = y_w;

`ifdef XOR86_ACTIVITY_EN
    logic [CNT_W-1:0] tog_w [NUM_GATES];
    assign tog1 = tog_w[0];
    assign tog2 = tog_w[1];
    assign tog3 = tog_w[2];
    assign tog4 = tog_w[3];
`endif

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        xor86_gate
`ifdef XOR86_ACTIVITY_EN
        #(.CNT_W(CNT_W))
`endif
        u_gate (
`ifdef XOR86_ACTIVITY_EN
            .clk (clk),
            .rst (rst),
            .tog (tog_w[g]),
`endif
            .a   (a_w[g]),
            .b   (b_w[g]),
            .y   (y_w[g])
        );
    end

    // Probe register next state.
    always_comb begin
        y_q_d = y_w;
        if (rst) begin
            y_q_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        y_q <= y_q_d;
    end

endmodule : xor_86p

// File: tb/tb_xor_86p.sv
// Directed and random self-checking bench for xor_86p.
module tb_xor_86p;

`ifdef XOR86_ACTIVITY_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 8;
`endif

    logic             clk;
    logic             rst;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       y;
    logic [3:0]       y_q;
`ifdef XOR86_ACTIVITY_EN
    logic [CNT_W-1:0] tog1, tog2, tog3, tog4;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit four_state;

    xor_86p #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .a1  (a[0]), .a2 (a[1]), .a3 (a[2]), .a4 (a[3]),
        .b1  (b[0]), .b2 (b[1]), .b3 (b[2]), .b4 (b[3]),
        .y1  (y[0]), .y2 (y[1]), .y3 (y[2]), .y4 (y[3]),
`ifdef XOR86_ACTIVITY_EN
        .tog1 (tog1), .tog2 (tog2), .tog3 (tog3), .tog4 (tog4),
`endif
        .y_q (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       probe;
        logic [3:0] ta;
        logic [3:0] tb;
        logic [3:0] exp_q;

        probe      = 1'bx;
        four_state = $isunknown(probe);

        // Reset state.
        rst = 1'b1;
        a   = 4'h0;
        b   = 4'h0;
        tick();
        check("reset_y_q", 32'(y_q), 32'h0);
        rst = 1'b0;

        // Test 1: each gate alone, others undriven-unknown. Vectors 00,10,11,01.
        for (int g = 0; g < 4; g++) begin
            ta = 4'b0110;   // a per vector
            tb = 4'b1100;   // b per vector
            for (int v = 0; v < 4; v++) begin
                a    = 4'bxxxx;
                b    = 4'bxxxx;
                a[g] = ta[v];
                b[g] = tb[v];
                #1;
                check($sformatf("gate%0d_vec%0d", g + 1, v), 32'(y[g]), 32'(ta[v] ^ tb[v]));
                if (four_state) begin
                    for (int o = 0; o < 4; o++) begin
                        if (o != g) begin
                            check($sformatf("gate%0d_other%0d_x", g + 1, o + 1),
                                  32'($isunknown(y[o])), 32'h1);
                        end
                    end
                end
            end
        end
        // Hand-computed truth table spot checks on gate 1.
        a = 4'b0001; b = 4'b0000; #1; check("tt_10", 32'(y[0]), 32'h1);
        a = 4'b0001; b = 4'b0001; #1; check("tt_11", 32'(y[0]), 32'h0);

        // Test 2: all gates, registered copy after one edge.
        a = 4'b1010;
        b = 4'b0110;
        #1;
        check("all_y", 32'(y), 32'hC);
        tick();
        check("all_y_q", 32'(y_q), 32'hC);

        // Test 3: reset mid-operation.
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'h0;
        #1;
        check("rst_y_live", 32'(y), 32'hF);
        tick();
        check("rst_y_q_clr", 32'(y_q), 32'h0);
        check("rst_y_hold", 32'(y), 32'hF);
        rst = 1'b0;
        tick();
        check("rst_release_y_q", 32'(y_q), 32'hF);

        // Test 4: X isolation.
        a    = 4'b0000;
        b    = 4'b0000;
        a[0] = 1'bx;
        #1;
        check("xiso_y4_2", 32'(y[3:1]), 32'h0);
        if (four_state) begin
            check("xiso_y1_x", 32'($isunknown(y[0])), 32'h1);
        end

`ifdef XOR86_ACTIVITY_EN
        // Test 5: saturating toggle counter on gate 1.
        a   = 4'h0;
        b   = 4'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a[0] = ~a[0];
            tick();
            check($sformatf("tog1_step%0d", i), 32'(tog1), (i < 2) ? 32'(i + 1) : 32'h3);
        end
        check("tog2_idle", 32'(tog2), 32'h0);
        check("tog3_idle", 32'(tog3), 32'h0);
        check("tog4_idle", 32'(tog4), 32'h0);
        rst = 1'b1;
        tick();
        check("tog_rst", 32'({tog4, tog3, tog2, tog1}), 32'h0);
        rst = 1'b0;
`endif

        // Test 6: random vectors.
        for (int i = 0; i < 1000; i++) begin
            ta = 4'($urandom);
            tb = 4'($urandom);
            a  = ta;
            b  = tb;
            #1;
            exp_q = ta ^ tb;
            check("rand_y", 32'(y), 32'(exp_q));
            tick();
            check("rand_y_q", 32'(y_q), 32'(exp_q));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_xor_86p
